// File: rtl/frame_color_detector_pkg.sv
// frame_color_detector_pkg: shared verdict codes, RGB332 field layout, classification limits and FSM/row types
package frame_color_detector_pkg;
  localparam logic [1:0] COLOR_NONE = 2'b00;
  localparam logic [1:0] COLOR_RED = 2'b01;
  localparam logic [1:0] COLOR_BLUE = 2'b10;
  localparam logic [1:0] SHAPE_NONE = 2'b00;
  localparam logic [1:0] SHAPE_TRIANGLE = 2'b01;
  localparam logic [1:0] SHAPE_SQUARE = 2'b10;
  localparam logic [1:0] SHAPE_DIAMOND = 2'b11;
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;
  localparam logic [2:0] RED_R_MIN = 3'd5;
  localparam logic [2:0] RED_G_MAX = 3'd2;
  localparam logic [1:0] RED_B_MAX = 2'd1;
  localparam logic [1:0] BLUE_B_MIN = 2'd2;
  localparam logic [2:0] BLUE_R_MAX = 3'd2;
  localparam logic [2:0] BLUE_G_MAX = 3'd3;
  typedef enum logic [1:0] {ROW_NONE, ROW_TOP, ROW_MID, ROW_BOT} row_t;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE} state_t;
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/rgb332_classifier.sv
// rgb332_classifier: one-cycle registered red/blue/ROI/row classification of the pixel write stream
module rgb332_classifier
  import frame_color_detector_pkg::*;
#(
  parameter int X_LO = 48,
  parameter int X_HI = 128,
  parameter int Y_LO = 32,
  parameter int Y_HI = 112
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VSYNC,
  input  logic        PIX_VALID,
  input  logic [14:0] X_ADDR,
  input  logic [14:0] Y_ADDR,
  input  logic [7:0]  PIX_DATA,
  output logic        is_red,
  output logic        is_blue,
  output logic        in_roi,
  output row_t        row_tag,
  output logic        vsync_d
);
  localparam int ROW_TOP_Y = Y_LO + 8;
  localparam int ROW_MID_Y = (Y_LO + Y_HI) / 2;
  localparam int ROW_BOT_Y = Y_HI - 9;
  logic [2:0] r, g;
  logic [1:0] b;
  logic roi_hit;
  row_t row_nx;
  assign r = PIX_DATA[R_MSB:R_LSB];
  assign g = PIX_DATA[G_MSB:G_LSB];
  assign b = PIX_DATA[B_MSB:B_LSB];
  assign roi_hit = X_ADDR >= 15'(X_LO) && X_ADDR < 15'(X_HI) && Y_ADDR >= 15'(Y_LO) && Y_ADDR < 15'(Y_HI);
  assign row_nx = Y_ADDR == 15'(ROW_TOP_Y) ? ROW_TOP :
                  Y_ADDR == 15'(ROW_MID_Y) ? ROW_MID :
                  Y_ADDR == 15'(ROW_BOT_Y) ? ROW_BOT : ROW_NONE;
  // in_roi already folds in write enable and blanking, so it is the single count qualifier downstream
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      is_red  <= 1'b0;
      is_blue <= 1'b0;
      in_roi  <= 1'b0;
      row_tag <= ROW_NONE;
      vsync_d <= 1'b0;
    end else begin
      is_red  <= r >= RED_R_MIN && g <= RED_G_MAX && b <= RED_B_MAX;
      is_blue <= b >= BLUE_B_MIN && r <= BLUE_R_MAX && g <= BLUE_G_MAX;
      in_roi  <= PIX_VALID && !VSYNC && roi_hit;
      row_tag <= row_nx;
      vsync_d <= VSYNC;
    end
endmodule

// File: rtl/frame_color_detector.sv
// frame_color_detector: per-frame red/blue ROI pixel counts with a valid/ack verdict register; SHAPE_DETECT_EN adds the shape verdict
module frame_color_detector
  import frame_color_detector_pkg::*;
#(
  parameter int X_LO = 48,
  parameter int X_HI = 128,
  parameter int Y_LO = 32,
  parameter int Y_HI = 112,
  parameter int CNT_W = 13,
  parameter int THRESH = 1000,
  parameter int SHAPE_TOL = 6
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VSYNC,
  input  logic        PIX_VALID,
  input  logic [14:0] X_ADDR,
  input  logic [14:0] Y_ADDR,
  input  logic [7:0]  PIX_DATA,
  output logic [3:0]  RESULT_DATA,
  output logic        RESULT_VALID,
  input  logic        RESULT_ACK,
  output logic        OVERRUN
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic is_red, is_blue, in_roi, vsync_d, vsync_dd, vsync_rise;
  row_t row_tag;
  state_t state, state_nx;
  logic [CNT_W-1:0] red_cnt, blue_cnt;
  logic [1:0] color, shape;
  rgb332_classifier #(.X_LO(X_LO), .X_HI(X_HI), .Y_LO(Y_LO), .Y_HI(Y_HI)) u_cls (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .PIX_VALID(PIX_VALID),
    .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR), .PIX_DATA(PIX_DATA),
    .is_red(is_red), .is_blue(is_blue), .in_roi(in_roi), .row_tag(row_tag), .vsync_d(vsync_d)
  );
  assign vsync_rise = vsync_d && !vsync_dd;
  // state register and delayed-VSYNC history for edge detection
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      state    <= S_IDLE;
      vsync_dd <= 1'b0;
    end else begin
      state    <= state_nx;
      vsync_dd <= vsync_d;
    end
  // IDLE only arms on the first blanking edge so a partial frame is never judged
  always_comb begin
    state_nx = state;
    state_nx = state == S_DECIDE ? S_ACCUM :
               vsync_rise ? (state == S_IDLE ? S_ACCUM : S_DECIDE) : state;
  end
  // saturating color counters, cleared once the verdict has been taken
  always_ff @(posedge CLK)
    if (!RESET_N || state == S_DECIDE) begin
      red_cnt  <= '0;
      blue_cnt <= '0;
    end else if (state == S_ACCUM && in_roi) begin
      if (is_red && red_cnt != CNT_MAX) red_cnt <= red_cnt + 1'b1;
      if (is_blue && blue_cnt != CNT_MAX) blue_cnt <= blue_cnt + 1'b1;
    end
  assign color = red_cnt > blue_cnt && red_cnt >= CNT_W'(THRESH) ? COLOR_RED :
                 blue_cnt > red_cnt && blue_cnt >= CNT_W'(THRESH) ? COLOR_BLUE : COLOR_NONE;
`ifdef SHAPE_DETECT_EN
  logic [7:0] w_top, w_mid, w_bot;
  logic [9:0] t, m, bo, tol;
  logic [1:0] shape_raw;
  // colored-pixel widths of the three probe rows
  always_ff @(posedge CLK)
    if (!RESET_N || state == S_DECIDE) begin
      w_top <= '0;
      w_mid <= '0;
      w_bot <= '0;
    end else if (state == S_ACCUM && in_roi && (is_red || is_blue)) begin
      if (row_tag == ROW_TOP && w_top != 8'hFF) w_top <= w_top + 1'b1;
      if (row_tag == ROW_MID && w_mid != 8'hFF) w_mid <= w_mid + 1'b1;
      if (row_tag == ROW_BOT && w_bot != 8'hFF) w_bot <= w_bot + 1'b1;
    end
  assign t = 10'(w_top);
  assign m = 10'(w_mid);
  assign bo = 10'(w_bot);
  assign tol = 10'(SHAPE_TOL);
  assign shape_raw = t + tol < m && m + tol < bo ? SHAPE_TRIANGLE :
                     abs_diff(t, m) <= tol && abs_diff(m, bo) <= tol ? SHAPE_SQUARE :
                     m > t + tol && m > bo + tol ? SHAPE_DIAMOND : SHAPE_NONE;
  assign shape = color == COLOR_NONE ? SHAPE_NONE : shape_raw;
`else
  logic unused_shape;
  assign unused_shape = ^{row_tag, 1'(SHAPE_TOL)};
  assign shape = SHAPE_NONE;
`endif
  // verdict register: a fresh load beats a same-cycle ack and flags any overwrite
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      RESULT_DATA  <= '0;
      RESULT_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else if (state == S_DECIDE) begin
      RESULT_DATA  <= {shape, color};
      RESULT_VALID <= 1'b1;
      OVERRUN      <= OVERRUN | RESULT_VALID;
    end else if (RESULT_ACK) begin
      RESULT_VALID <= 1'b0;
    end
endmodule

// File: tb/tb_frame_color_detector.sv
// tb_frame_color_detector: directed frames checked against a frame-level model and literal verdicts
module tb_frame_color_detector;
  localparam int X_LO = 48, X_HI = 128, Y_LO = 32, Y_HI = 112, THRESH = 1000, TOL = 6;
  localparam int ROW_T = Y_LO + 8, ROW_M = (Y_LO + Y_HI) / 2, ROW_B = Y_HI - 9;
`ifdef SHAPE_DETECT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  logic CLK = 0, RESET_N = 0, VSYNC = 0, PIX_VALID = 0, RESULT_ACK = 0;
  logic [14:0] X_ADDR = '0, Y_ADDR = '0;
  logic [7:0] PIX_DATA = '0;
  logic [3:0] RESULT_DATA;
  logic RESULT_VALID, OVERRUN;
  int checks = 0, errors = 0;
  bit run_chk = 0;

  frame_color_detector dut (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .PIX_VALID(PIX_VALID),
    .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR), .PIX_DATA(PIX_DATA),
    .RESULT_DATA(RESULT_DATA), .RESULT_VALID(RESULT_VALID),
    .RESULT_ACK(RESULT_ACK), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // frame-level model: integer pixel tallies, verdict published two edges after blanking starts
  int red_n, blue_n, w_t, w_m, w_b;
  bit armed, prev_vs;
  longint cyc = 0, load_at = -1;
  logic [3:0] load_val, m_data;
  logic m_valid, m_ovr;

  function automatic logic [3:0] verdict(input int rn, input int bn, input int t, input int m, input int b);
    int col, shp;
    col = (rn > bn && rn >= THRESH) ? 1 : (bn > rn && bn >= THRESH) ? 2 : 0;
    shp = 0;
    if (SH && col != 0) begin
      if (t + TOL < m && m < b - TOL) shp = 1;
      else if ((t - m <= TOL && m - t <= TOL) && (m - b <= TOL && b - m <= TOL)) shp = 2;
      else if (m > t + TOL && m > b + TOL) shp = 3;
    end
    return 4'(shp * 4 + col);
  endfunction

  always @(posedge CLK) begin
    int v, r, g, b, x, y;
    bit red, blue;
    cyc++;
    if (!RESET_N) begin
      red_n = 0; blue_n = 0; w_t = 0; w_m = 0; w_b = 0;
      armed = 0; prev_vs = 0; load_at = -1;
      m_data = 0; m_valid = 0; m_ovr = 0;
    end else begin
      if (cyc == load_at) begin
        m_ovr = m_ovr | m_valid;
        m_valid = 1;
        m_data = load_val;
      end else if (RESULT_ACK) m_valid = 0;
      v = int'(PIX_DATA); x = int'(X_ADDR); y = int'(Y_ADDR);
      r = v / 32; g = (v / 4) % 8; b = v % 4;
      red = r >= 5 && g <= 2 && b <= 1;
      blue = b >= 2 && r <= 2 && g <= 3;
      if (armed && PIX_VALID && !VSYNC && x >= X_LO && x < X_HI && y >= Y_LO && y < Y_HI) begin
        if (red) red_n++;
        if (blue) blue_n++;
        if (red || blue) begin
          if (y == ROW_T) w_t++;
          if (y == ROW_M) w_m++;
          if (y == ROW_B) w_b++;
        end
      end
      if (VSYNC && !prev_vs) begin
        if (armed) begin
          load_val = verdict(red_n, blue_n, w_t, w_m, w_b);
          load_at = cyc + 2;
          red_n = 0; blue_n = 0; w_t = 0; w_m = 0; w_b = 0;
        end
        armed = 1;
      end
      prev_vs = VSYNC;
    end
  end

  always @(negedge CLK) if (run_chk) begin
    checks++;
    if ({RESULT_VALID, RESULT_DATA, OVERRUN} !== {m_valid, m_data, m_ovr}) begin
      errors++;
      $display("FAIL model_cmp t=%0t got v=%b d=%b o=%b expected v=%b d=%b o=%b",
               $time, RESULT_VALID, RESULT_DATA, OVERRUN, m_valid, m_data, m_ovr);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int x, input int y);
    int i, w;
    i = (y - Y_LO) * (X_HI - X_LO) + (x - X_LO);
    case (pat)
      0: return 8'hE0;
      1: return i < 3000 ? 8'h03 : i < 5000 ? 8'hE0 : 8'hFF;
      2: return i < 900 ? 8'h03 : 8'h00;
      3: return i < 1500 ? 8'hE0 : i < 3000 ? 8'h03 : 8'h00;
      4: return i >= 5400 ? 8'hE0 : 8'h00;
      5, 6: begin
        w = y == ROW_T ? (pat == 5 ? 10 : 20) : y == ROW_M ? (pat == 5 ? 40 : 70) :
            y == ROW_B ? (pat == 5 ? 70 : 20) : 30;
        return (x - X_LO) < w ? 8'hE0 : 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic send_frame(input int pat, input int y0, input int y1);
    for (int y = y0; y < y1; y++)
      for (int x = X_LO; x < X_HI; x++) begin
        @(negedge CLK);
        PIX_VALID = 1; X_ADDR = 15'(x); Y_ADDR = 15'(y); PIX_DATA = pix(pat, x, y);
      end
  endtask

  task automatic send_outside();
    for (int k = 0; k < 5250; k++) begin
      int j, xo, yo;
      @(negedge CLK);
      j = k % 5; xo = X_LO + (k / 5) % 80; yo = Y_LO + (k / 5) % 80;
      PIX_DATA = 8'hE0;
      PIX_VALID = j != 4;
      X_ADDR = 15'(j == 0 ? X_HI : j == 1 ? X_LO - 1 : xo);
      Y_ADDR = 15'(j == 2 ? Y_HI : j == 3 ? Y_LO - 1 : yo);
    end
  endtask

  task automatic vsync(input bit ack_on_load, output logic v1, output logic v2, output logic [3:0] d2, output logic o2);
    @(negedge CLK); VSYNC = 1; PIX_VALID = 0;
    @(negedge CLK);
    @(negedge CLK); v1 = RESULT_VALID; RESULT_ACK = ack_on_load;
    @(negedge CLK); v2 = RESULT_VALID; d2 = RESULT_DATA; o2 = OVERRUN; RESULT_ACK = 0;
    repeat (3) @(negedge CLK);
    VSYNC = 0;
    @(negedge CLK);
  endtask

  task automatic ack();
    @(negedge CLK); RESULT_ACK = 1;
    @(negedge CLK); RESULT_ACK = 0;
    check("ack_clears_valid", 8'(RESULT_VALID), 8'd0);
  endtask

  initial begin
    logic v1, v2, o2;
    logic [3:0] d2;
    @(negedge CLK); run_chk = 1;
    repeat (3) @(negedge CLK);
    check("reset_data", 8'(RESULT_DATA), 8'h0);
    check("reset_valid", 8'(RESULT_VALID), 8'h0);
    check("reset_overrun", 8'(OVERRUN), 8'h0);
    RESET_N = 1;
    send_frame(2, Y_LO, Y_LO + 3);
    vsync(0, v1, v2, d2, o2);
    check("idle_no_verdict", 8'(v2), 8'd0);
    send_frame(2, Y_LO, Y_LO + 13);
    vsync(0, v1, v2, d2, o2);
    check("blue900_t1_valid", 8'(v1), 8'd0);
    check("blue900_t2_valid", 8'(v2), 8'd1);
    check("blue900_data", 8'(d2), 8'h0);
    ack();
    send_frame(0, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("red_t1_valid", 8'(v1), 8'd0);
    check("red_t2_valid", 8'(v2), 8'd1);
    check("red_data", 8'(d2), SH ? 8'h9 : 8'h1);
    ack();
    send_frame(1, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("blue_win_data", 8'(d2), 8'h2);
    check("no_overrun_yet", 8'(o2), 8'd0);
    send_frame(0, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("overwrite_data", 8'(d2), SH ? 8'h9 : 8'h1);
    check("overrun_set", 8'(o2), 8'd1);
    send_frame(3, Y_LO, Y_LO + 38);
    vsync(1, v1, v2, d2, o2);
    check("tie_data", 8'(d2), 8'h0);
    check("ack_on_load_valid", 8'(RESULT_VALID), 8'd1);
    ack();
    send_outside();
    vsync(0, v1, v2, d2, o2);
    check("outside_data", 8'(d2), 8'h0);
    check("outside_valid", 8'(v2), 8'd1);
    ack();
    send_frame(4, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("thresh_last_pixel", 8'(d2), 8'h1);
    ack();
    send_frame(0, Y_LO, Y_LO + 40);
    @(negedge CLK); RESET_N = 0; PIX_VALID = 0;
    @(negedge CLK); RESET_N = 1;
    check("reset_clears_overrun", 8'(OVERRUN), 8'd0);
    send_frame(0, Y_LO + 40, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("post_reset_no_verdict", 8'(v2), 8'd0);
    send_frame(1, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("post_reset_data", 8'(d2), 8'h2);
    check("post_reset_valid", 8'(v2), 8'd1);
    ack();
    send_frame(5, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("triangle_data", 8'(d2), SH ? 8'h5 : 8'h1);
    ack();
    send_frame(6, Y_LO, Y_HI);
    vsync(0, v1, v2, d2, o2);
    check("diamond_data", 8'(d2), SH ? 8'hD : 8'h1);
    ack();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
